// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and FSM state type.
package serial_sub_pkg;

  localparam int unsigned SubWidthDefault = 12;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sub_state_t;

endpackage

// File: rtl/full_sub_bit.sv
// Combinational one-bit full subtractor: d = x - y - bin, bout set when the bit underflows.
module full_sub_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_xy;

  assign w_xy = x ^ y;
  assign d    = w_xy ^ bin;
  assign bout = (~x & y) | (~w_xy & bin);

endmodule

// File: rtl/serial_sub12.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), LSB first, one bit per clock,
// with the final borrow. Results are held until the next completed operation.
module serial_sub12
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SubWidthDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  sub_state_t       r_state, w_state_d;
  logic [WIDTH-1:0] r_a_sh, w_a_sh_d;
  logic [WIDTH-1:0] r_b_sh, w_b_sh_d;
  logic [WIDTH-1:0] r_r_sh, w_r_sh_d;
  logic             r_bw, w_bw_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [WIDTH-1:0] r_diff, w_diff_d;
  logic             r_borrow, w_borrow_d;
  logic             r_busy, r_done;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_r_shifted;

  full_sub_bit u_bit (
    .x    (r_a_sh[0]),
    .y    (r_b_sh[0]),
    .bin  (r_bw),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_r_shifted = {w_d, r_r_sh[WIDTH-1:1]};

  always_comb begin
    w_state_d  = r_state;
    w_a_sh_d   = r_a_sh;
    w_b_sh_d   = r_b_sh;
    w_r_sh_d   = r_r_sh;
    w_bw_d     = r_bw;
    w_cnt_d    = r_cnt;
    w_diff_d   = r_diff;
    w_borrow_d = r_borrow;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_a_sh_d  = a;
          w_b_sh_d  = b;
          w_bw_d    = 1'b0;
          w_cnt_d   = '0;
          w_state_d = SHIFT;
        end
      end
      SHIFT: begin
        w_r_sh_d = w_r_shifted;
        w_a_sh_d = {1'b0, r_a_sh[WIDTH-1:1]};
        w_b_sh_d = {1'b0, r_b_sh[WIDTH-1:1]};
        w_bw_d   = w_bout;
        if (r_cnt == CntLast) begin
          // Hold the count on the last bit so power-of-two widths never wrap.
          w_diff_d   = w_r_shifted;
          w_borrow_d = w_bout;
          w_state_d  = DONE;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      DONE: begin
        w_state_d = IDLE;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_r_sh   <= '0;
      r_bw     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_a_sh   <= w_a_sh_d;
      r_b_sh   <= w_b_sh_d;
      r_r_sh   <= w_r_sh_d;
      r_bw     <= w_bw_d;
      r_cnt    <= w_cnt_d;
      r_diff   <= w_diff_d;
      r_borrow <= w_borrow_d;
      // Status flags are flopped from the next state so every output is a register.
      r_busy   <= (w_state_d != IDLE);
      r_done   <= (w_state_d == DONE);
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_sub12.sv
// Randomized self-checking bench for serial_sub12 at WIDTH=12 and WIDTH=4, against a
// cycle-schedule model of accept/done timing and plain-arithmetic subtraction.
module tb_serial_sub12;

  localparam int W12 = 12;
  localparam int W4  = 4;

  logic          clk;
  logic          rst_n;
  logic          start12, start4;
  logic [11:0]   a12, b12, diff12;
  logic [3:0]    a4, b4, diff4;
  logic          busy12, done12, borrow12;
  logic          busy4, done4, borrow4;

  int n_checks;
  int n_errors;

  // Model state: edge counter, last acceptance edge, earliest next accept, held results.
  int          cyc;
  bit          act12, act4;
  int          acc12, acc4;
  int          na12, na4;
  logic [12:0] pend12;
  logic [4:0]  pend4;
  logic [11:0] res12;
  logic [3:0]  res4;
  logic        rb12, rb4;
  int          n_acc12, n_done12;

  serial_sub12 #(.WIDTH(W12)) u_dut12 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start12),
    .a      (a12),
    .b      (b12),
    .busy   (busy12),
    .done   (done12),
    .diff   (diff12),
    .borrow (borrow12)
  );

  serial_sub12 #(.WIDTH(W4)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start4),
    .a      (a4),
    .b      (b4),
    .busy   (busy4),
    .done   (done4),
    .diff   (diff4),
    .borrow (borrow4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_busy12"}, 32'(busy12), 32'd0);
    check_eq({tag, "_done12"}, 32'(done12), 32'd0);
    check_eq({tag, "_diff12"}, 32'(diff12), 32'd0);
    check_eq({tag, "_borrow12"}, 32'(borrow12), 32'd0);
    check_eq({tag, "_busy4"}, 32'(busy4), 32'd0);
    check_eq({tag, "_done4"}, 32'(done4), 32'd0);
    check_eq({tag, "_diff4"}, 32'(diff4), 32'd0);
    check_eq({tag, "_borrow4"}, 32'(borrow4), 32'd0);
  endtask

  // Asserts reset mid-cycle with random inputs, holds it for n edges, releases after an edge.
  task automatic do_reset(input int n);
    start12 = 1'($urandom);
    a12     = 12'($urandom);
    b12     = 12'($urandom);
    start4  = 1'($urandom);
    a4      = 4'($urandom);
    b4      = 4'($urandom);
    rst_n   = 1'b0;
    #1;
    check_zero_outputs("rst_async");
    repeat (n) @(posedge clk);
    #1;
    check_zero_outputs("rst_hold");
    rst_n = 1'b1;
    act12 = 1'b0;
    act4  = 1'b0;
    na12  = 0;
    na4   = 0;
    res12 = '0;
    res4  = '0;
    rb12  = 1'b0;
    rb4   = 1'b0;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare all outputs 1 unit later.
  task automatic step(input logic s12, input logic [11:0] x12, input logic [11:0] y12,
                      input logic s4, input logic [3:0] x4, input logic [3:0] y4);
    bit exp_done;
    start12 = s12;
    a12     = x12;
    b12     = y12;
    start4  = s4;
    a4      = x4;
    b4      = y4;
    @(posedge clk);
    cyc++;
    if (s12 && cyc >= na12) begin
      act12  = 1'b1;
      acc12  = cyc;
      na12   = cyc + W12 + 2;
      pend12 = {1'b0, x12} - {1'b0, y12};
      n_acc12++;
    end
    if (s4 && cyc >= na4) begin
      act4  = 1'b1;
      acc4  = cyc;
      na4   = cyc + W4 + 2;
      pend4 = {1'b0, x4} - {1'b0, y4};
    end
    #1;
    exp_done = act12 && (cyc == acc12 + W12);
    if (exp_done) begin
      res12 = pend12[11:0];
      rb12  = pend12[12];
    end
    if (done12) n_done12++;
    check_eq("busy12", 32'(busy12), 32'(act12 && (cyc <= acc12 + W12)));
    check_eq("done12", 32'(done12), 32'(exp_done));
    check_eq("diff12", 32'(diff12), 32'(res12));
    check_eq("borrow12", 32'(borrow12), 32'(rb12));

    exp_done = act4 && (cyc == acc4 + W4);
    if (exp_done) begin
      res4 = pend4[3:0];
      rb4  = pend4[4];
    end
    check_eq("busy4", 32'(busy4), 32'(act4 && (cyc <= acc4 + W4)));
    check_eq("done4", 32'(done4), 32'(exp_done));
    check_eq("diff4", 32'(diff4), 32'(res4));
    check_eq("borrow4", 32'(borrow4), 32'(rb4));
  endtask

  task automatic idle_steps(input int n);
    repeat (n) step(1'b0, 12'($urandom), 12'($urandom), 1'b0, 4'($urandom), 4'($urandom));
  endtask

  // One directed 12-bit operation; operands are scrambled after acceptance.
  task automatic op12(input logic [11:0] x, input logic [11:0] y);
    step(1'b1, x, y, 1'b0, 4'($urandom), 4'($urandom));
    idle_steps(W12 + 1);
  endtask

  task automatic op4(input logic [3:0] x, input logic [3:0] y);
    step(1'b0, 12'($urandom), 12'($urandom), 1'b1, x, y);
    idle_steps(W4 + 1);
  endtask

  initial begin
    int dn_before;
    int guard;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    n_acc12  = 0;
    n_done12 = 0;
    acc12    = 0;
    acc4     = 0;
    pend12   = '0;
    pend4    = '0;
    rst_n    = 1'b0;

    do_reset(3);
    idle_steps(2);

    op12(12'h123, 12'h012);
    check_eq("basic_diff", 32'(diff12), 32'h111);
    check_eq("basic_borrow", 32'(borrow12), 32'd0);
    idle_steps(3);
    check_eq("basic_hold", 32'(diff12), 32'h111);

    op12(12'h000, 12'h001);
    check_eq("under_diff", 32'(diff12), 32'hFFF);
    check_eq("under_borrow", 32'(borrow12), 32'd1);
    op12(12'h800, 12'h7FF);
    check_eq("mid_diff", 32'(diff12), 32'h001);
    check_eq("mid_borrow", 32'(borrow12), 32'd0);
    op12(12'hFFF, 12'hFFF);
    check_eq("eq_diff", 32'(diff12), 32'h000);
    check_eq("eq_borrow", 32'(borrow12), 32'd0);

    op4(4'h3, 4'h5);
    check_eq("w4_diff", 32'(diff4), 32'hE);
    check_eq("w4_borrow", 32'(borrow4), 32'd1);

    // start held high with operands changing every cycle: one done per WIDTH+2 cycles.
    dn_before = n_done12;
    repeat (3 * (W12 + 2)) step(1'b1, 12'($urandom), 12'($urandom), 1'b0, 4'h0, 4'h0);
    check_eq("hold_start_dones", 32'(n_done12 - dn_before), 32'd3);
    idle_steps(W12 + 2);

    // Reset after E5 of an in-flight operation: no done, outputs cleared.
    step(1'b1, 12'h0F0, 12'h00F, 1'b1, 4'h9, 4'h2);
    idle_steps(5);
    #3;
    do_reset(2);
    op12(12'h00A, 12'h003);
    check_eq("rst_recover_diff", 32'(diff12), 32'h007);
    check_eq("rst_recover_borrow", 32'(borrow12), 32'd0);

    // Random regression with random start gaps, both widths in parallel.
    n_acc12 = 0;
    guard   = 0;
    while (n_acc12 < 2000 && guard < 60000) begin
      step(1'($urandom_range(0, 2) == 0), 12'($urandom), 12'($urandom),
           1'($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom));
      guard++;
    end
    check_eq("regress_ops", 32'(n_acc12 >= 2000), 32'd1);
    idle_steps(W12 + 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
